// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair (shift-add / restoring divide).
// Optional MULDIV_ZERO_SKIP_EN: zero-operand multiply or zero-divisor divide skips straight to SIGN.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t           state, state_nxt;
    logic [4:0]       cnt;
    logic             is_div, neg_main, neg_rem, dz_pend;
    logic [WIDTH-1:0] opa, opb, acc_hi, acc_lo;

    logic             signed_op, a_neg, b_neg, skip;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, rem_next;
    logic [WIDTH+1:0] div_diff;
    logic             rem_unused;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v,
                                                  input logic n);
        return n ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic signed [2*WIDTH-1:0] v,
                                                         input logic n);
        return n ? $unsigned(-v) : $unsigned(v);
    endfunction

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & srcA[WIDTH-1];
    assign b_neg     = signed_op & srcB[WIDTH-1];
    assign mag_a     = magnitude(srcA, signed_op);
    assign mag_b     = magnitude(srcB, signed_op);
    assign busy      = (state != IDLE);

`ifdef MULDIV_ZERO_SKIP_EN
    assign skip = op[1] ? (srcB == '0) : ((srcA == '0) || (srcB == '0));
`else
    assign skip = 1'b0;
`endif

    // One iteration: multiply adds the multiplicand into the upper half and shifts right;
    // divide shifts the next dividend bit into the remainder and keeps it only if no borrow.
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
    assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b0, opb};
    assign rem_next   = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
    assign rem_unused = rem_next[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = skip ? SIGN : CALC;
            CALC:    if (cnt == 5'd31) state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        dz_pend  <= op[1] && (srcB == '0);
                        dz       <= 1'b0;
                    end
                end
                CALC: cnt <= cnt + 5'd1;
                SIGN: begin
                    if (is_div) begin
                        lo <= cond_neg(acc_lo, neg_main);
                        hi <= cond_neg(acc_hi, neg_rem);
                    end else begin
                        {hi, lo} <= cond_neg_wide({acc_hi, acc_lo}, neg_main);
                    end
                    done <= 1'b1;
                    dz   <= dz_pend;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded at acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opa <= mag_a;
            opb <= mag_b;
            if (op[1]) begin
                acc_hi <= skip ? mag_a : '0;
                acc_lo <= skip ? '1 : mag_a;
            end else begin
                acc_hi <= '0;
                acc_lo <= skip ? '0 : mag_b;
            end
        end else if (state == CALC) begin
            if (is_div) begin
                acc_hi <= rem_next[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. The EX stage issues MULT/MULTU/DIV/DIVU here instead of to the single-cycle ALU. A start/busy/done handshake lets hazard logic stall MFHI/MFLO and new mul/div issues until the result is committed. Internal 33-bit add/subtract plus shift datapath, one iteration per cycle; MTHI/MTLO writes come in through dedicated ports.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported and verified.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA  in  32  multiplicand / dividend.
- srcB  in  32  multiplier / divisor.
- hi_we  in  1  MTHI write enable; honoured only when not busy.
- lo_we  in  1  MTLO write enable; honoured only when not busy.
- wdata  in  32  MTHI/MTLO write data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- dz  out  1  last divide had a zero divisor; held until the next accepted start.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, start=1:
  - latch op;
  - latch magnitudes |srcA|, |srcB| (signed ops) or raw values (unsigned ops);
  - latch result-sign flags;
  - clear iteration counter to 0 and go to CALC.
- CALC: one iteration per cycle. Counter reaches 31 -> SIGN.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, 33-bit subtract on the partial remainder.
- SIGN, multiply: negate the 64-bit product if the operand signs differ (signed op only). Write {hi,lo}.
- SIGN, divide: LO = quotient, HI = remainder.
  - Signed op: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Then return to IDLE.
- Divide by zero: no special path. The natural restoring result is committed: LO=32'hFFFFFFFF, HI=|dividend|, then the sign rule above. dz=1.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No trap, no flag.
- start while busy: ignored, not queued.
- hi_we/lo_we while busy: dropped.
- hi_we/lo_we with start in the same IDLE cycle: both take effect; the write lands now and the operation result overwrites it at SIGN.
- Operands are sampled only at acceptance. srcA/srcB/op may change freely afterwards.

## Timing
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, dz=0; counter 0.
- Reset mid-operation: the operation is aborted and HI/LO are cleared. No done pulse.
- Acceptance edge E0 (IDLE, start=1): busy=1 from E0.
- CALC occupies edges E1..E32. SIGN commit occurs at E33.
- At E33: hi/lo updated, busy=0, done=1 for exactly one cycle.
- Latency start->done: 34 cycles. A new start may be accepted at E34, i.e. in the cycle done is high.
- dz updates at E0 (cleared) and E33 (set on a zero divisor).
- MTHI/MTLO: hi/lo update at the next edge, 1-cycle latency.

## Configuration
- MULDIV_ZERO_SKIP_EN defined: a multiply with either operand zero, or a divide with a zero divisor, goes IDLE -> SIGN directly.
  - The commit is at E1 and done is high in the cycle after E1: latency 2.
  - Result values and dz are identical to the full sequence.
- MULDIV_ZERO_SKIP_EN undefined: every operation takes the full 34 cycles.

## Test plan
- MULT srcA=0xFFFFFFFF, srcB=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly 34 cycles after start; busy high for 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, dz=1. A following MULTU 3x4 clears dz at acceptance -> lo=12, hi=0.
  - With MULDIV_ZERO_SKIP_EN: DIVU 5/0 gives done 2 cycles after start.
- Handshake:
  - start pulsed at cycle 5 of a running op -> ignored; the result is that of the first op.
  - hi_we=1, wdata=0x1234 while busy -> hi unchanged.
  - The same write in IDLE -> hi=0x1234 next cycle.
- rst asserted 10 cycles into a DIV -> next cycle: busy=0, hi=lo=0, done stays 0.
  - A start accepted after reset completes normally.
